// File: rtl/bcd_disp_pkg.sv
// Shared seven-segment constants and BCD decode for the scanned display.
// Patterns are active-high, with seg[0]=a through seg[6]=g.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

  function automatic logic nibble_invalid(input logic [3:0] nibble);
    return (nibble > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_scan_timer.sv
// Slot timer for the display scan: prescale counter, digit index,
// blank/show phase and a one-cycle pulse on the last cycle of each frame.
module bcd_scan_timer
  import bcd_disp_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 2,
  localparam int IDXW     = $clog2(NDIG)
) (
  input  logic            clk,
  input  logic            clr,
  output logic [IDXW-1:0] idx,
  output phase_e          phase,
  output logic            frame_end
);

  localparam int PCW = $clog2(PRESCALE);
  localparam logic [PCW-1:0]  PC_LAST   = PCW'(PRESCALE - 1);
  localparam logic [PCW-1:0]  BLANK_END = PCW'(BLANK_CYC);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);

  logic [PCW-1:0]  pc_q, pc_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            pc_wrap;

  always_comb begin
    pc_wrap = (pc_q == PC_LAST);
    pc_d    = pc_wrap ? '0 : pc_q + PCW'(1);
    idx_d   = idx_q;
    if (pc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q  <= '0;
      idx_q <= '0;
    end else begin
      pc_q  <= pc_d;
      idx_q <= idx_d;
    end
  end

  // The first BLANK_CYC cycles of every slot keep all anodes dark so the
  // previous digit's segments cannot ghost onto the next anode.
  assign phase     = (pc_q < BLANK_END) ? PH_BLANK : PH_SHOW;
  assign frame_end = pc_wrap && (idx_q == IDX_LAST);
  assign idx       = idx_q;

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode 7-segment driver for NDIG BCD digits with
// frame-aligned shadow updates, leading-zero suppression and a sticky error flag.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic              load,
  input  logic              lz_blank,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              err
);

  localparam int IDXW = $clog2(NDIG);
  localparam bit INVERT = (ACTIVE_LOW != 0);
  localparam logic [6:0]      SEG_IDLE = INVERT ? 7'h7F : 7'h00;
  localparam logic [NDIG-1:0] AN_IDLE  = INVERT ? {NDIG{1'b1}} : {NDIG{1'b0}};

  logic [IDXW-1:0] idx;
  phase_e          phase;
  logic            frame_end;

  bcd_scan_timer #(
    .NDIG      (NDIG),
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk       (clk),
    .clr       (clr),
    .idx       (idx),
    .phase     (phase),
    .frame_end (frame_end)
  );

  logic [4*NDIG-1:0] staging_q, staging_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;

  // A load coinciding with the frame boundary goes straight to the shadow,
  // so the freshest value wins and nothing is left pending.
  always_comb begin
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (load) begin
      staging_d = digits_in;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        shadow_d  = digits_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = staging_q;
        pending_d = 1'b0;
      end
    end
  end

  logic [3:0] nib [NDIG];

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib
    assign nib[gi] = shadow_q[4*gi +: 4];
  end

  // lz_mask[k] is set when digit k and every digit above it are zero.
  logic [NDIG-1:0] lz_mask;
  logic            zero_run;

  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      zero_run   = zero_run && (nib[k] == 4'd0);
      lz_mask[k] = zero_run;
    end
  end

  logic [3:0]      cur_nib;
  logic            cur_blank;
  logic [NDIG-1:0] an_act;
  logic [6:0]      seg_act;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            err_q, err_d;

  always_comb begin
    cur_nib   = nib[idx];
    cur_blank = lz_blank && lz_mask[idx];
    an_act    = '0;
    seg_act   = SEG_OFF;
    err_d     = err_q;
    if (phase == PH_SHOW) begin
      an_act[idx] = 1'b1;
      if (!cur_blank) begin
        seg_act = bcd_to_seg(cur_nib);
      end
      if (nibble_invalid(cur_nib)) begin
        err_d = 1'b1;
      end
    end
    an_d  = INVERT ? ~an_act  : an_act;
    seg_d = INVERT ? ~seg_act : seg_act;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= AN_IDLE;
      seg_q     <= SEG_IDLE;
      err_q     <= 1'b0;
    end else begin
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      err_q     <= err_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display (NDIG=4, PRESCALE=4, BLANK_CYC=1),
// with a second active-low instance for the asynchronous clear case.
module tb_bcd_scan_display;

  localparam int ND  = 4;
  localparam int PRE = 4;
  localparam int BLK = 1;
  localparam int FRAME = ND * PRE;

  logic        clk;
  logic        clr, clr2;
  logic [15:0] digits, digits2;
  logic        load, load2;
  logic        lz, lz2;
  logic [6:0]  seg, seg2;
  logic [3:0]  an, an2;
  logic        err, err2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_scan_display #(
    .NDIG(ND), .PRESCALE(PRE), .BLANK_CYC(BLK), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .clr(clr), .digits_in(digits), .load(load), .lz_blank(lz),
    .seg(seg), .an(an), .err(err)
  );

  bcd_scan_display #(
    .NDIG(ND), .PRESCALE(PRE), .BLANK_CYC(BLK), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .clr(clr2), .digits_in(digits2), .load(load2), .lz_blank(lz2),
    .seg(seg2), .an(an2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [15:0] digits;
    logic        lz;
    logic [27:0] segs;   // {d3, d2, d1, d0}
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance one edge and compare the registered outputs against the slot
  // the counters were in just before that edge.
  task automatic check_cycle(input bit al, input logic [27:0] segs, input bit e_err);
    int         pc, idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    step();
    pc    = (cyc - 1) % PRE;
    idx   = ((cyc - 1) / PRE) % ND;
    e_an  = 4'b0000;
    e_seg = 7'h00;
    if (pc >= BLK) begin
      e_an[idx] = 1'b1;
      e_seg     = segs[idx*7 +: 7];
    end
    if (al) begin
      chk("an_al",  {28'd0, an2},  {28'd0, ~e_an});
      chk("seg_al", {25'd0, seg2}, {25'd0, ~e_seg});
      chk("err_al", {31'd0, err2}, {31'd0, e_err});
    end else begin
      chk("an",  {28'd0, an},  {28'd0, e_an});
      chk("seg", {25'd0, seg}, {25'd0, e_seg});
      chk("err", {31'd0, err}, {31'd0, e_err});
    end
  endtask

  task automatic run_to(input int m, input bit al, input logic [27:0] segs, input bit e_err);
    while (cyc % FRAME != m) check_cycle(al, segs, e_err);
  endtask

  task automatic check_frame(input bit al, input logic [27:0] segs, input bit e_err);
    repeat (FRAME) check_cycle(al, segs, e_err);
  endtask

  logic [27:0] cur;
  localparam logic [27:0] ALL_ZERO = {7'h3F, 7'h3F, 7'h3F, 7'h3F};

  initial begin
    vecs[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'h0050, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[3] = '{16'h9876, 1'b0, {7'h6F, 7'h7F, 7'h07, 7'h7D}};
    vecs[4] = '{16'h0100, 1'b1, {7'h00, 7'h06, 7'h3F, 7'h3F}};
    vecs[5] = '{16'h0008, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h7F}};

    clr = 1'b0; clr2 = 1'b0;
    load = 1'b0; load2 = 1'b0;
    digits = 16'h0; digits2 = 16'h0;
    lz = 1'b0; lz2 = 1'b0;

    // Reset window and first frames: scan order, blanking and period.
    #3;
    clr = 1'b1; clr2 = 1'b1;
    #4;
    chk("rst_an",      {28'd0, an},   32'h0);
    chk("rst_seg",     {25'd0, seg},  32'h0);
    chk("rst_err",     {31'd0, err},  32'h0);
    chk("rst_an_al",   {28'd0, an2},  32'hF);
    chk("rst_seg_al",  {25'd0, seg2}, 32'h7F);
    #3;
    clr = 1'b0; clr2 = 1'b0;
    cur = ALL_ZERO;
    check_frame(1'b0, cur, 1'b0);
    check_frame(1'b0, cur, 1'b0);
    $display("reset/scan: frames of shadow 0000 checked up to cyc=%0d", cyc);

    // Table: load mid-frame (during digit 1), old value holds to the boundary.
    for (int i = 0; i < 6; i++) begin
      run_to(5, 1'b0, cur, 1'b0);
      load = 1'b1; digits = vecs[i].digits;
      check_cycle(1'b0, cur, 1'b0);
      load = 1'b0;
      run_to(0, 1'b0, cur, 1'b0);
      lz = vecs[i].lz;
      check_frame(1'b0, vecs[i].segs, 1'b0);
      cur = vecs[i].segs;
      $display("vec %0d: digits=%h lz=%b segs=%h", i, vecs[i].digits, vecs[i].lz, vecs[i].segs);
    end

    // Two loads in one frame: only the later one reaches the display.
    run_to(3, 1'b0, cur, 1'b0);
    load = 1'b1; digits = 16'h0007;
    check_cycle(1'b0, cur, 1'b0);
    load = 1'b0;
    run_to(8, 1'b0, cur, 1'b0);
    load = 1'b1; digits = 16'h0902;
    check_cycle(1'b0, cur, 1'b0);
    load = 1'b0;
    run_to(0, 1'b0, cur, 1'b0);
    cur = {7'h3F, 7'h6F, 7'h3F, 7'h5B};
    check_frame(1'b0, cur, 1'b0);
    $display("double load: 0007 then 0902 -> 0902");

    // Load on the frame_end edge overrides an older pending value.
    run_to(5, 1'b0, cur, 1'b0);
    load = 1'b1; digits = 16'h0001;
    check_cycle(1'b0, cur, 1'b0);
    load = 1'b0;
    run_to(15, 1'b0, cur, 1'b0);
    load = 1'b1; digits = 16'h5555;
    check_cycle(1'b0, cur, 1'b0);
    load = 1'b0;
    cur = {7'h6D, 7'h6D, 7'h6D, 7'h6D};
    check_frame(1'b0, cur, 1'b0);
    $display("boundary load: 5555 shown in next frame");

    // Invalid nibble: dash on digit 1, err rises on its first SHOW cycle.
    run_to(5, 1'b0, cur, 1'b0);
    load = 1'b1; digits = 16'h00A3;
    check_cycle(1'b0, cur, 1'b0);
    load = 1'b0;
    run_to(0, 1'b0, cur, 1'b0);
    cur = {7'h3F, 7'h3F, 7'h40, 7'h4F};
    for (int i = 1; i <= FRAME; i++) check_cycle(1'b0, cur, (i >= 6));
    run_to(5, 1'b0, cur, 1'b1);
    load = 1'b1; digits = 16'h0003;
    check_cycle(1'b0, cur, 1'b1);
    load = 1'b0;
    run_to(0, 1'b0, cur, 1'b1);
    cur = {7'h3F, 7'h3F, 7'h3F, 7'h4F};
    check_frame(1'b0, cur, 1'b1);
    $display("err: set by 00A3, held through 0003");

    // Clear pulse on both instances between edges.
    #1;
    clr = 1'b1; clr2 = 1'b1;
    #1;
    chk("clr_an",  {28'd0, an},  32'h0);
    chk("clr_seg", {25'd0, seg}, 32'h0);
    chk("clr_err", {31'd0, err}, 32'h0);
    #1;
    clr = 1'b0; clr2 = 1'b0;
    cyc = 0;
    check_frame(1'b0, ALL_ZERO, 1'b0);
    $display("clr pulse: err cleared, shadow back to 0000");

    // Active-low instance: clear during digit 2 SHOW with a load pending.
    check_frame(1'b1, ALL_ZERO, 1'b0);
    run_to(8, 1'b1, ALL_ZERO, 1'b0);
    load2 = 1'b1; digits2 = 16'h0777;
    check_cycle(1'b1, ALL_ZERO, 1'b0);
    load2 = 1'b0;
    check_cycle(1'b1, ALL_ZERO, 1'b0);
    check_cycle(1'b1, ALL_ZERO, 1'b0);
    chk("al_pre_clr_an", {28'd0, an2}, 32'hB);
    #1;
    clr2 = 1'b1;
    #1;
    chk("al_clr_an",  {28'd0, an2},  32'hF);
    chk("al_clr_seg", {25'd0, seg2}, 32'h7F);
    chk("al_clr_err", {31'd0, err2}, 32'h0);
    #1;
    clr2 = 1'b0;
    cyc = 0;
    check_frame(1'b1, ALL_ZERO, 1'b0);
    check_frame(1'b1, ALL_ZERO, 1'b0);
    $display("active-low clr: pending 0777 discarded");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
